adder_stream_stage: RTL and testbench

//  Datapath stage downstream of the user_ip AXI4-Lite/DRM control block in the adder pipe.
//  - Adds the host-programmed mailbox addend to each 32-bit AXI4-Stream word, but only while the
//    DRM activation flag is high; otherwise the word passes through unchanged.
//  - Counts words delivered while activated and emits one metering pulse per METER_PERIOD words.
//    The pulse feeds the DRM activator's metering_event input.

---
 rtl/adder_stream_stage_if.sv | 24 ++
 rtl/adder_stream_stage.sv | 158 +++++++++++++++
 tb/tb_adder_stream_stage.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_stream_stage_if.sv
// AXI4-Stream word channel (data, end-of-packet, valid/ready) shared by the adder stage ports.
// The master drives payload and valid; the slave drives ready.
interface adder_stream_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/adder_stream_stage.sv
// Stream stage that adds the mailbox addend to each word while DRM-activated, with a
// two-entry (main + skid) buffer, sticky carry flag and activated-word metering.
module adder_stream_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int METER_PERIOD = 1024,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  activated,
    input  logic [DATA_WIDTH-1:0] addend,
    input  logic                  carry_clr,
    adder_stream_stage_if.slave   s_axis,
    adder_stream_stage_if.master  m_axis,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  metering_pulse,
    output logic                  carry_flag
);
    localparam logic [CNT_WIDTH-1:0] METER_LAST = CNT_WIDTH'(METER_PERIOD - 1);

    logic                  r_main_valid;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic                  r_main_last;
    logic                  r_main_act;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_last;
    logic                  r_skid_act;
    logic                  r_s_ready;
    logic [CNT_WIDTH-1:0]  r_meter_cnt;
    logic [CNT_WIDTH-1:0]  r_word_count;
    logic                  r_metering_pulse;
    logic                  r_carry_flag;

    logic                  w_acc;
    logic                  w_out_hs;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_carry;

    logic                  w_main_valid_next;
    logic [DATA_WIDTH-1:0] w_main_data_next;
    logic                  w_main_last_next;
    logic                  w_main_act_next;
    logic                  w_skid_valid_next;
    logic [DATA_WIDTH-1:0] w_skid_data_next;
    logic                  w_skid_last_next;
    logic                  w_skid_act_next;

    assign w_acc    = s_axis.tvalid & r_s_ready;
    assign w_out_hs = r_main_valid & m_axis.tready;

    // activated/addend are captured with the word at accept and never revisited.
    assign w_sum    = {1'b0, s_axis.tdata} + {1'b0, addend};
    assign w_result = activated ? w_sum[DATA_WIDTH-1:0] : s_axis.tdata;
    assign w_carry  = activated & w_sum[DATA_WIDTH];

    always_comb begin
        w_main_valid_next = r_main_valid;
        w_main_data_next  = r_main_data;
        w_main_last_next  = r_main_last;
        w_main_act_next   = r_main_act;
        w_skid_valid_next = r_skid_valid;
        w_skid_data_next  = r_skid_data;
        w_skid_last_next  = r_skid_last;
        w_skid_act_next   = r_skid_act;

        if (w_out_hs) begin
            // A valid skid implies tready was low, so no accept can coincide with draining it.
            if (r_skid_valid) begin
                w_main_data_next  = r_skid_data;
                w_main_last_next  = r_skid_last;
                w_main_act_next   = r_skid_act;
                w_skid_valid_next = 1'b0;
            end else if (w_acc) begin
                w_main_data_next  = w_result;
                w_main_last_next  = s_axis.tlast;
                w_main_act_next   = activated;
            end else begin
                w_main_valid_next = 1'b0;
            end
        end else if (w_acc) begin
            if (!r_main_valid) begin
                w_main_valid_next = 1'b1;
                w_main_data_next  = w_result;
                w_main_last_next  = s_axis.tlast;
                w_main_act_next   = activated;
            end else begin
                w_skid_valid_next = 1'b1;
                w_skid_data_next  = w_result;
                w_skid_last_next  = s_axis.tlast;
                w_skid_act_next   = activated;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_last  <= 1'b0;
            r_main_act   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_act   <= 1'b0;
            r_s_ready    <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_next;
            r_main_data  <= w_main_data_next;
            r_main_last  <= w_main_last_next;
            r_main_act   <= w_main_act_next;
            r_skid_valid <= w_skid_valid_next;
            r_skid_data  <= w_skid_data_next;
            r_skid_last  <= w_skid_last_next;
            r_skid_act   <= w_skid_act_next;
            r_s_ready    <= ~w_skid_valid_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry_flag <= 1'b0;
        end else if (w_acc && w_carry) begin
            r_carry_flag <= 1'b1;
        end else if (carry_clr) begin
            r_carry_flag <= 1'b0;
        end
    end

    // Only words that were accepted while activated are metered, counted at their output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meter_cnt      <= '0;
            r_word_count     <= '0;
            r_metering_pulse <= 1'b0;
        end else begin
            r_metering_pulse <= 1'b0;
            if (w_out_hs && r_main_act) begin
                r_word_count <= r_word_count + 1'b1;
                if (r_meter_cnt == METER_LAST) begin
                    r_meter_cnt      <= '0;
                    r_metering_pulse <= 1'b1;
                end else begin
                    r_meter_cnt <= r_meter_cnt + 1'b1;
                end
            end
        end
    end

    assign s_axis.tready  = r_s_ready;
    assign m_axis.tvalid  = r_main_valid;
    assign m_axis.tdata   = r_main_data;
    assign m_axis.tlast   = r_main_last;
    assign word_count     = r_word_count;
    assign metering_pulse = r_metering_pulse;
    assign carry_flag     = r_carry_flag;
endmodule

// File: tb/tb_adder_stream_stage.sv
// Directed bench for adder_stream_stage: add/passthrough, carry, backpressure, reset, metering.
module tb_adder_stream_stage;
    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk;
    logic          rst_n;
    logic          activated;
    logic [DW-1:0] addend;
    logic          carry_clr;
    logic [CW-1:0] word_count;
    logic          metering_pulse;
    logic          carry_flag;

    int checks = 0;
    int errors = 0;

    adder_stream_stage_if #(.DATA_WIDTH(DW)) s_if ();
    adder_stream_stage_if #(.DATA_WIDTH(DW)) m_if ();

    adder_stream_stage #(
        .DATA_WIDTH  (DW),
        .METER_PERIOD(4),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .activated     (activated),
        .addend        (addend),
        .carry_clr     (carry_clr),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .word_count    (word_count),
        .metering_pulse(metering_pulse),
        .carry_flag    (carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        activated = 1'b0; addend = '0; carry_clr = 1'b0;
        s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0; m_if.tready = 1'b1;
        #2;
        checks++;
        if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0 || word_count !== 32'd0 ||
            metering_pulse !== 1'b0 || carry_flag !== 1'b0 || m_if.tdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: mtv=%b str=%b wc=%0d mp=%b cf=%b td=%h required all 0",
                     m_if.tvalid, s_if.tready, word_count, metering_pulse, carry_flag, m_if.tdata);
        end
        step();
        rst_n = 1'b1;
        checks++;
        if (s_if.tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: s_tready=%b required 0 before first edge", s_if.tready);
        end
        step();
        checks++;
        if (s_if.tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise: s_tready=%b required 1", s_if.tready);
        end
        $display("test_reset done");
    endtask

    task automatic test_add();
        logic [DW-1:0] exp_d [3];
        exp_d[0] = 32'd6; exp_d[1] = 32'd7; exp_d[2] = 32'd8;
        activated = 1'b1; addend = 32'd5; m_if.tready = 1'b1;
        s_if.tvalid = 1'b1; s_if.tlast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_if.tdata = DW'(i + 1);
            step();
            checks++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== exp_d[i] || s_if.tready !== 1'b1) begin
                errors++;
                $display("FAIL add_word%0d: tvalid=%b tdata=%0d s_tready=%b required 1/%0d/1",
                         i, m_if.tvalid, m_if.tdata, s_if.tready, exp_d[i]);
            end
            $display("add word %0d -> %0d", i + 1, m_if.tdata);
        end
        s_if.tvalid = 1'b0;
        step();
        checks++;
        if (word_count !== 32'd3 || m_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL add_count: word_count=%0d tvalid=%b required 3/0", word_count, m_if.tvalid);
        end
    endtask

    task automatic test_passthrough();
        activated = 1'b0; addend = 32'd5;
        s_if.tdata = 32'hA; s_if.tvalid = 1'b1;
        step();
        s_if.tvalid = 1'b0;
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'hA) begin
            errors++;
            $display("FAIL pass_data: tvalid=%b tdata=%h required 1/0000000a", m_if.tvalid, m_if.tdata);
        end
        step();
        checks++;
        if (word_count !== 32'd3 || carry_flag !== 1'b0 || metering_pulse !== 1'b0) begin
            errors++;
            $display("FAIL pass_counters: wc=%0d cf=%b mp=%b required 3/0/0",
                     word_count, carry_flag, metering_pulse);
        end
        $display("passthrough word 0xA -> %h", m_if.tdata);
    endtask

    task automatic test_carry();
        activated = 1'b1; addend = 32'd1;
        s_if.tdata = 32'hFFFF_FFFF; s_if.tvalid = 1'b1;
        step();
        checks++;
        if (m_if.tdata !== 32'd0 || m_if.tvalid !== 1'b1 || carry_flag !== 1'b1) begin
            errors++;
            $display("FAIL carry_set: tdata=%h tvalid=%b cf=%b required 0/1/1",
                     m_if.tdata, m_if.tvalid, carry_flag);
        end
        carry_clr = 1'b1;
        step();
        s_if.tvalid = 1'b0;
        checks++;
        if (carry_flag !== 1'b1) begin
            errors++;
            $display("FAIL carry_set_wins: cf=%b required 1", carry_flag);
        end
        // word 4 of the period (after three in test_add) handshaked at the last edge
        checks++;
        if (metering_pulse !== 1'b1) begin
            errors++;
            $display("FAIL carry_meter_wrap: mp=%b required 1", metering_pulse);
        end
        step();
        carry_clr = 1'b0;
        checks++;
        if (carry_flag !== 1'b0 || word_count !== 32'd5 || metering_pulse !== 1'b0) begin
            errors++;
            $display("FAIL carry_clear: cf=%b wc=%0d mp=%b required 0/5/0",
                     carry_flag, word_count, metering_pulse);
        end
        $display("carry test flag=%b word_count=%0d", carry_flag, word_count);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] got_d [$];
        logic          got_l [$];
        logic          acc_now;
        activated = 1'b0; m_if.tready = 1'b0;
        s_if.tvalid = 1'b1; s_if.tdata = 32'd1; s_if.tlast = 1'b1;
        step();
        s_if.tdata = 32'd2; s_if.tlast = 1'b0;
        step();
        s_if.tdata = 32'd3; s_if.tlast = 1'b1;
        checks++;
        if (s_if.tready !== 1'b0 || m_if.tdata !== 32'd1 || m_if.tlast !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: s_tready=%b tdata=%0d tlast=%b required 0/1/1",
                     s_if.tready, m_if.tdata, m_if.tlast);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'd1 || m_if.tlast !== 1'b1 ||
                s_if.tready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stable%0d: tvalid=%b tdata=%0d tlast=%b s_tready=%b required 1/1/1/0",
                         c, m_if.tvalid, m_if.tdata, m_if.tlast, s_if.tready);
            end
        end
        m_if.tready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (m_if.tvalid === 1'b1) begin
                got_d.push_back(m_if.tdata);
                got_l.push_back(m_if.tlast);
            end
            acc_now = s_if.tvalid & s_if.tready;
            step();
            if (acc_now) s_if.tvalid = 1'b0;
        end
        checks++;
        if (got_d.size() != 3 || s_if.tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain_count: words=%0d pending_in=%b required 3/0",
                     got_d.size(), s_if.tvalid);
        end else begin
            checks++;
            if (got_d[0] !== 32'd1 || got_d[1] !== 32'd2 || got_d[2] !== 32'd3 ||
                got_l[0] !== 1'b1 || got_l[1] !== 1'b0 || got_l[2] !== 1'b1) begin
                errors++;
                $display("FAIL bp_order: got %0d/%b %0d/%b %0d/%b required 1/1 2/0 3/1",
                         got_d[0], got_l[0], got_d[1], got_l[1], got_d[2], got_l[2]);
            end
            $display("backpressure drained %0d %0d %0d", got_d[0], got_d[1], got_d[2]);
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int seen;
        activated = 1'b1; addend = 32'd5; m_if.tready = 1'b0;
        s_if.tvalid = 1'b1; s_if.tdata = 32'hFFFF_FFFF; s_if.tlast = 1'b0;
        step();
        s_if.tdata = 32'd7;
        step();
        s_if.tvalid = 1'b0;
        checks++;
        if (m_if.tvalid !== 1'b1 || s_if.tready !== 1'b0 || carry_flag !== 1'b1) begin
            errors++;
            $display("FAIL rst_prefill: tvalid=%b s_tready=%b cf=%b required 1/0/1",
                     m_if.tvalid, s_if.tready, carry_flag);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0 || word_count !== 32'd0 ||
            carry_flag !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: tvalid=%b s_tready=%b wc=%0d cf=%b required 0/0/0/0",
                     m_if.tvalid, s_if.tready, word_count, carry_flag);
        end
        step();
        rst_n = 1'b1;
        m_if.tready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (m_if.tvalid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || word_count !== 32'd0 || s_if.tready !== 1'b1) begin
            errors++;
            $display("FAIL rst_no_stale: stale=%0d wc=%0d s_tready=%b required 0/0/1",
                     seen, word_count, s_if.tready);
        end
        $display("reset mid-flight stale words=%0d", seen);
    endtask

    task automatic test_metering();
        int pulses;
        logic exp_p;
        activated = 1'b1; addend = 32'd0; m_if.tready = 1'b1;
        s_if.tvalid = 1'b1; s_if.tdata = 32'd1; s_if.tlast = 1'b0;
        pulses = 0;
        for (int e = 1; e <= 11; e++) begin
            step();
            if (e < 9) s_if.tdata = DW'(e + 1);
            else s_if.tvalid = 1'b0;
            exp_p = (e == 5 || e == 9);
            if (metering_pulse === 1'b1) pulses++;
            checks++;
            if (metering_pulse !== exp_p) begin
                errors++;
                $display("FAIL meter_edge%0d: pulse=%b required %b", e, metering_pulse, exp_p);
            end
        end
        checks++;
        if (word_count !== 32'd9 || pulses != 2) begin
            errors++;
            $display("FAIL meter_total: wc=%0d pulses=%0d required 9/2", word_count, pulses);
        end
        $display("metering words=%0d pulses=%0d", word_count, pulses);
    endtask

    initial begin
        test_reset();
        test_add();
        test_passthrough();
        test_carry();
        test_backpressure();
        test_reset_midflight();
        test_metering();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
